// File: rtl/cache_i_assoc.sv
// N-way set-associative instruction cache with multi-word lines and round-robin replacement.
// Hits answer combinationally; misses refill the whole line one word per RAM request.
module cache_i_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_busy,
  input  logic                  ram_ready,
  input  logic [DATA_WIDTH-1:0] ram_data
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int SB  = $clog2(SETS);
  localparam int TW  = ADDR_WIDTH - 2 - WB - SB;
  localparam int WYB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BTB = (LINE_WORDS > 1) ? WB : 1;
  localparam logic [BTB-1:0] LAST_BEAT = BTB'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [DATA_WIDTH-1:0] line_mem [WAYS][SETS][LINE_WORDS];
  logic [TW-1:0]         tag_mem  [WAYS][SETS];
  logic [SETS-1:0]       valid_mem[WAYS];
  logic [WYB-1:0]        rr_ptr   [SETS];

  logic [1:0]            state;
  logic [BTB-1:0]        beat;
  logic [ADDR_WIDTH-1:0] miss_base;
  logic [SB-1:0]         miss_idx;
  logic [TW-1:0]         miss_tag;
  logic [WYB-1:0]        miss_way;
  logic                  miss_fresh;

  logic [BTB-1:0]        req_word;
  logic [SB-1:0]         req_idx;
  logic [TW-1:0]         req_tag;
  logic                  byte_unused;

  logic                  hit;
  logic [WYB-1:0]        hit_way;
  logic                  free_found;
  logic [WYB-1:0]        free_way;
  logic [WYB-1:0]        victim;

  assign req_idx     = addr[2+WB +: SB];
  assign req_tag     = addr[ADDR_WIDTH-1 -: TW];
  assign byte_unused = ^addr[1:0];

  generate
    if (LINE_WORDS > 1) begin : g_word
      assign req_word = addr[2 +: WB];
    end else begin : g_single
      assign req_word = '0;
    end
  endgenerate

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WYB'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; the downward scan leaves it last-assigned.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[w][req_idx]) begin
        free_found = 1'b1;
        free_way   = WYB'(w);
      end
    end
  end

  assign victim = free_found ? free_way : rr_ptr[req_idx];
  assign ready  = read && !reset && !flush && (state == S_IDLE) && hit;
  assign data   = ready ? line_mem[hit_way][req_idx][req_word] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      beat       <= '0;
      ram_read   <= 1'b0;
      ram_addr   <= '0;
      miss_base  <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      miss_way   <= '0;
      miss_fresh <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_mem[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      ram_read <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read && !hit && !flush) begin
            miss_base  <= {req_tag, req_idx, {(WB+2){1'b0}}};
            miss_idx   <= req_idx;
            miss_tag   <= req_tag;
            miss_way   <= victim;
            miss_fresh <= free_found;
            // The stale line must not hit while its slots are being overwritten.
            valid_mem[victim][req_idx] <= 1'b0;
            beat       <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (!ram_busy) begin
            ram_read <= 1'b1;
            ram_addr <= miss_base + (ADDR_WIDTH'(beat) << 2);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= ram_ready ? S_IDLE : S_DRAIN;
          end else if (ram_ready) begin
            if (beat == LAST_BEAT) begin
              valid_mem[miss_way][miss_idx] <= 1'b1;
              tag_mem[miss_way][miss_idx]   <= miss_tag;
              if (!miss_fresh) rr_ptr[miss_idx] <= (WAYS > 1) ? WYB'(miss_way + 1'b1) : '0;
              state <= S_IDLE;
            end else begin
              beat  <= beat + 1'b1;
              state <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (ram_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (flush) begin
        for (int w = 0; w < WAYS; w++) valid_mem[w] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && state == S_WAIT && ram_ready) begin
      line_mem[miss_way][miss_idx][beat] <= ram_data;
    end
  end

endmodule

// File: tb/tb_cache_i_assoc.sv
// Directed bench for cache_i_assoc: refill timing, replacement, busy stall, flush, redirect, reset.
module tb_cache_i_assoc;

  logic        clock = 1'b0;
  logic        reset, flush, read, ram_busy;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_data  = '0;
  logic [31:0] addr;
  logic        ready, ram_read;
  logic [31:0] data, ram_addr;

  int          compares = 0;
  int          mism     = 0;
  logic [31:0] log_q[$];
  int          pend = 0;
  logic [31:0] pend_addr = '0;

  cache_i_assoc dut (
    .clock(clock), .reset(reset), .flush(flush), .read(read), .addr(addr),
    .ready(ready), .data(data), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_busy(ram_busy), .ram_ready(ram_ready), .ram_data(ram_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ {a[31:2], 2'b00};
  endfunction

  // RAM answers the cycle after it sees a request (k = 2 in the refill timing).
  always @(negedge clock) begin
    ram_ready = 1'b0;
    ram_data  = '0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ram_ready = 1'b1;
        ram_data  = mem_word(pend_addr);
      end
    end
    if (ram_read === 1'b1) begin
      log_q.push_back(ram_addr);
      pend      = 1;
      pend_addr = ram_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_lat, input string tag);
    int n = 0;
    @(negedge clock);
    read = 1'b1;
    addr = a;
    #1;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " data"}, data, mem_word(a));
    read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    reset = 1'b1; flush = 1'b0; read = 1'b1; addr = 32'h100; ram_busy = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset ready", ready, 0);
    chk("reset data", data, 0);
    chk("reset ram_read", ram_read, 0);
    chk("reset ram_addr", ram_addr, 0);
    @(negedge clock);
    reset = 1'b0; read = 1'b0;

    // Cold miss, then same-line hits
    base = log_q.size();
    fetch(32'h100, 13, "t1 cold 0x100");
    chk("t1 beat count", log_q.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("t1 beat addr", log_q[base+i], 32'h100 + 32'(4*i));
    fetch(32'h104, 0, "t1 hit 0x104");
    fetch(32'h10C, 0, "t1 hit 0x10C");
    repeat (3) @(negedge clock);
    #1;
    chk("t1 no ram_read on hits", log_q.size() - base, 4);

    // Three tags in one set: round-robin eviction
    fetch(32'h1100, 13, "t2 fill 0x1100");
    fetch(32'h2100, 13, "t2 fill 0x2100");
    fetch(32'h1100, 0, "t2 0x1100 kept");
    fetch(32'h2100, 0, "t2 0x2100 hit");
    fetch(32'h100, 13, "t2 0x100 evicted");
    fetch(32'h2100, 0, "t2 pointer advanced");
    fetch(32'h1100, 13, "t2 0x1100 evicted");

    // ram_busy for 3 cycles on the beat-2 request
    base = log_q.size();
    @(negedge clock);
    read = 1'b1; addr = 32'h200;
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
      ram_busy = (n >= 7 && n <= 9);
      #1;
      if (n >= 8 && n <= 10) chk("t3 ram_read held", ram_read, 0);
      if (n == 11) begin
        chk("t3 ram_read pulse", ram_read, 1);
        chk("t3 ram_addr", ram_addr, 32'h208);
      end
    end
    ram_busy = 1'b0;
    chk("t3 latency", n, 16);
    chk("t3 data", data, mem_word(32'h200));
    read = 1'b0;
    chk("t3 beat count", log_q.size() - base, 4);
    fetch(32'h208, 0, "t3 hit 0x208");
    fetch(32'h20C, 0, "t3 hit 0x20C");

    // flush gates a hit in the same cycle
    @(negedge clock);
    read = 1'b1; addr = 32'h104; flush = 1'b1;
    #1;
    chk("t4 flush ready", ready, 0);
    chk("t4 flush data", data, 0);
    @(negedge clock);
    flush = 1'b0; read = 1'b0;

    // flush while waiting on beat 1: drain, then full refetch
    base = log_q.size();
    @(negedge clock);
    read = 1'b1; addr = 32'h300;
    repeat (5) @(negedge clock);
    flush = 1'b1;
    #1;
    chk("t4 beat1 ram_read", ram_read, 1);
    chk("t4 beat1 ram_addr", ram_addr, 32'h304);
    @(negedge clock);
    flush = 1'b0;
    #1;
    n = 1;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("t4 latency after flush", n, 15);
    chk("t4 data 0x300", data, mem_word(32'h300));
    read = 1'b0;
    chk("t4 beat count", log_q.size() - base, 6);
    chk("t4 restart addr", log_q[base+2], 32'h300);
    base = log_q.size();
    fetch(32'h100, 13, "t4 0x100 refetch");
    chk("t4 0x100 first beat", log_q[base], 32'h100);

    // addr redirect mid-refill
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    base = log_q.size();
    @(negedge clock);
    read = 1'b1; addr = 32'h100;
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 5) addr = 32'h400;
      #1;
    end
    chk("t5 latency", n, 26);
    chk("t5 data", data, mem_word(32'h400));
    read = 1'b0;
    chk("t5 beat count", log_q.size() - base, 8);
    chk("t5 last old beat", log_q[base+3], 32'h10C);
    chk("t5 first new beat", log_q[base+4], 32'h400);
    fetch(32'h100, 0, "t5 0x100 completed");

    // reset in WAIT with the response arriving one cycle later
    base = log_q.size();
    @(negedge clock);
    read = 1'b1; addr = 32'h600;
    repeat (2) @(negedge clock);
    reset = 1'b1; read = 1'b0;
    #1;
    chk("t6 in wait", ram_read, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6 ready", ready, 0);
    chk("t6 data", data, 0);
    chk("t6 ram_read", ram_read, 0);
    chk("t6 ram_addr", ram_addr, 0);
    repeat (3) @(negedge clock);
    #1;
    chk("t6 no further beats", log_q.size() - base, 1);
    fetch(32'h100, 13, "t6 0x100 after reset");
    fetch(32'h600, 13, "t6 0x600 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end

endmodule
